uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Frame parser downstream of the UART byte receiver. It consumes the `data_byte`/`Rx_Done` stream, delineates fixed-format command frames and verifies an additive checksum. Each accepted frame's command, length and payload are presented to the control logic behind a valid/ack handshake. Malformed frames are discarded, and every discard is reported as an error pulse with a cause code.

## Interface
- `HEADER`, 8'h55: frame start byte.
- `MAX_LEN`, 16: maximum payload bytes. Legal range is 2..255.
- `TIMEOUT_CYC`, 50000: allowed inter-byte gap, in `Clk` cycles, inside a frame.

Ports (name, direction, width, meaning):
- `Clk`  in  1  system clock; one clock domain only.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `data_byte`  in  8  received byte; valid only when `Rx_Done` is high.
- `Rx_Done`  in  1  single-cycle byte strobe from the receiver.
- `cmd`  out  8  command byte of the held frame.
- `len`  out  8  payload length of the held frame.
- `rd_addr`  in  $clog2(MAX_LEN)  payload read index.
- `rd_data`  out  8  payload byte at `rd_addr`; registered.
- `frame_valid`  out  1  level; a frame is held and readable.
- `frame_ack`  in  1  consumer releases the held frame.
- `frame_err`  out  1  single-cycle error pulse.
- `err_code`  out  2  error cause, held until the next error: 0 = checksum, 1 = length > `MAX_LEN`, 2 = timeout, 3 = overrun.

## Operation
- Frame format: `HEADER`, CMD, LEN, LEN payload bytes, CHK.
- CHK = (CMD + LEN + all payload bytes) mod 256.
- States IDLE, CMD, LEN, DATA, CHK, HOLD. All transitions except HOLD exit and timeout occur only on `Rx_Done`.
- IDLE: a byte equal to `HEADER` moves to CMD. Any other byte is ignored silently.
- CMD: store `cmd`; sum <= byte; go to LEN.
- LEN:
  - byte > `MAX_LEN`: error code 1, go to IDLE.
  - otherwise store `len`, sum += byte, idx <= 0.
  - go to CHK if len == 0, else DATA.
- DATA: write buffer[idx], sum += byte, idx++. After the byte with idx == len-1, go to CHK.
- CHK:
  - byte == sum: go to HOLD.
  - otherwise: error code 0, go to IDLE.
- HOLD:
  - `frame_valid` = 1; `cmd`, `len` and buffer contents are frozen.
  - `frame_ack` moves to IDLE.
  - `Rx_Done` in HOLD: byte dropped, error code 3, remain in HOLD.
  - `frame_ack` and `Rx_Done` in the same cycle: go to IDLE, byte dropped, error code 3 raised.
- `frame_ack` outside HOLD is ignored.
- Reading `rd_addr` >= `len` returns stale buffer content. This is not an error.
- Header bytes inside a frame are treated as data. There is no resynchronisation mid-frame.

## Timing
- Reset values: `frame_valid` 0, `frame_err` 0, `err_code` 0, `cmd` 0, `len` 0, `rd_data` 0, state IDLE. Buffer contents are not reset.
- With `Rx_Done` at edge n:
  - the state update is visible at n+1;
  - `frame_valid` rises at n+1 after the CHK byte;
  - `frame_err` pulses for exactly cycle n+1, with `err_code` valid from n+1.
- `frame_ack` sampled at edge m: `frame_valid` low from m+1.
- A `HEADER` byte arriving at m+1 or later is accepted.
- `rd_data` latency is 1 cycle from `rd_addr`.
- Reset asserted mid-frame aborts the frame with no error pulse.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - a gap counter runs in CMD, LEN, DATA and CHK;
  - it clears on `Rx_Done` and in IDLE/HOLD;
  - at `TIMEOUT_CYC`-1 it raises error code 2 and returns to IDLE;
  - `Rx_Done` on the same cycle as expiry: the byte wins and the counter clears.
- Undefined: no counter exists; the parser waits indefinitely mid-frame and code 2 is never produced.

## Structure
- Package `uart_cmd_pkg`: state encoding, error-code constants, default `HEADER`.
- Sub-module `uart_cmd_buf`: `MAX_LEN`x8 simple dual-port RAM, synchronous write, registered read.

## Test plan
- Good frame: 55 01 02 AA BB 68 -> `frame_valid`=1, `cmd`=01, `len`=02; `rd_addr` 0 -> AA and 1 -> BB, one cycle later. Pulse `frame_ack` -> `frame_valid`=0 next cycle.
- Bad checksum: 55 01 02 AA BB 69 -> `frame_err` pulse, `err_code`=0, no `frame_valid`. A following good frame is accepted.
- Zero-length frame: 55 10 00 10 -> `frame_valid`, `len`=0.
- Oversized length: leading garbage 12 34 is ignored; then 55 01 11 (17) -> `err_code`=1, state IDLE.
- Overrun: good frame held, then byte 77 without ack -> `err_code`=3, buffer and `cmd` unchanged. Same-cycle ack plus byte -> IDLE, `err_code`=3.
- Timeout (macro on, `TIMEOUT_CYC`=100): 55 01, then 100 idle cycles -> `err_code`=2. Repeat with a gap of 99 cycles -> no error. With the macro off, no error after 1000 idle cycles.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared definitions for the UART command-frame parser.
//   - state_e           : parser state encoding
//   - ERR_*             : err_code cause values
//   - HEADER_DEFAULT    : default frame start byte
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_HOLD
    } state_e;

    localparam logic [1:0] ERR_CHKSUM  = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf
//   Payload buffer: simple dual-port RAM, synchronous write, registered read.
//   Contents are not reset; only the read register is.
//   Ports:
//     clk_i, rst_ni      clock, async active-low reset (read register only)
//     we_i, waddr_i,
//     wdata_i            write port
//     raddr_i, rdata_o   read port, 1-cycle latency
module uart_cmd_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    // Sized to the full address space so any rd_addr is a legal index.
    logic [7:0] mem_q [2**AW];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else         rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Delineates HEADER/CMD/LEN/payload/CHK frames from the UART byte stream,
//   verifies the additive checksum and holds accepted frames for the consumer.
//   Ports:
//     Clk, Rst_n            clock, async active-low reset
//     data_byte, Rx_Done    received byte and its single-cycle strobe
//     cmd, len              command and payload length of the held frame
//     rd_addr, rd_data      payload read port, 1-cycle latency
//     frame_valid           a frame is held and readable
//     frame_ack             consumer releases the held frame
//     frame_err, err_code   error pulse and held cause code
//   Build option: UART_CMD_TIMEOUT_EN enables the inter-byte gap timeout.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [7:0]                 data_byte,
    input  logic                       Rx_Done,
    output logic [7:0]                 cmd,
    output logic [7:0]                 len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    output logic                       frame_valid,
    input  logic                       frame_ack,
    output logic                       frame_err,
    output logic [1:0]                 err_code
);
    localparam int unsigned AW        = $clog2(MAX_LEN);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q;
    logic [7:0] cmd_q, len_q, sum_q, idx_q;
    logic [7:0] sum_d;
    logic       frame_valid_q, frame_err_q;
    logic [1:0] err_code_q;
    logic       timeout_hit;
    logic       buf_we;

    assign sum_d  = sum_q + data_byte;
    assign buf_we = (state_q == ST_DATA) && Rx_Done;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] gap_q;
    logic          in_frame;

    assign in_frame    = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                         (state_q == ST_DATA) || (state_q == ST_CHK);
    // A byte on the expiry cycle takes priority over the timeout.
    assign timeout_hit = in_frame && !Rx_Done && (gap_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                           gap_q <= '0;
        else if (Rx_Done || !in_frame || timeout_hit) gap_q <= '0;
        else                                  gap_q <= gap_q + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            len_q         <= '0;
            sum_q         <= '0;
            idx_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_CHKSUM;
        end else begin
            frame_err_q <= 1'b0;
            if (timeout_hit) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (Rx_Done && data_byte == HEADER) state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (Rx_Done) begin
                            cmd_q   <= data_byte;
                            sum_q   <= data_byte;
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (Rx_Done) begin
                            if (data_byte > MAX_LEN_B) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_LEN;
                                state_q     <= ST_IDLE;
                            end else begin
                                len_q   <= data_byte;
                                sum_q   <= sum_d;
                                idx_q   <= '0;
                                state_q <= (data_byte == 8'd0) ? ST_CHK : ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (Rx_Done) begin
                            sum_q <= sum_d;
                            idx_q <= idx_q + 8'd1;
                            if (idx_q == len_q - 8'd1) state_q <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (Rx_Done) begin
                            if (data_byte == sum_q) begin
                                state_q       <= ST_HOLD;
                                frame_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_CHKSUM;
                                state_q     <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Bytes arriving while held are dropped, even on the ack cycle.
                        if (Rx_Done) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_OVERRUN;
                        end
                        if (frame_ack) begin
                            state_q       <= ST_IDLE;
                            frame_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .we_i    (buf_we),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (data_byte),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign cmd         = cmd_q;
    assign len         = len_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Directed-vector bench for uart_cmd_parser (TIMEOUT_CYC overridden to 100).
//   Timeout checks follow UART_CMD_TIMEOUT_EN.
module tb_uart_cmd_parser;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [7:0] data_byte;
    logic       Rx_Done;
    logic [7:0] cmd, len, rd_data;
    logic [3:0] rd_addr;
    logic       frame_valid, frame_ack, frame_err;
    logic [1:0] err_code;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    always #5 Clk = ~Clk;

    uart_cmd_parser #(
        .HEADER      (8'h55),
        .MAX_LEN     (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .data_byte   (data_byte),
        .Rx_Done     (Rx_Done),
        .cmd         (cmd),
        .len         (len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err),
        .err_code    (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Strobe one byte; returns on the falling edge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge Clk);
        data_byte = b;
        Rx_Done   = 1'b1;
        @(negedge Clk);
        Rx_Done   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge Clk);
        rd_addr = a;
        @(negedge Clk);
        check(tag, rd_data, exp);
    endtask

    task automatic ack_chk(input string tag);
        @(negedge Clk);
        frame_ack = 1'b1;
        @(negedge Clk);
        frame_ack = 1'b0;
        check(tag, frame_valid, 0);
    endtask

    initial begin
        Rst_n     = 1'b0;
        data_byte = '0;
        Rx_Done   = 1'b0;
        rd_addr   = '0;
        frame_ack = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_valid", frame_valid, 0);
        check("rst_err",   frame_err, 0);
        check("rst_code",  err_code, 0);
        check("rst_cmd",   cmd, 0);
        check("rst_len",   len, 0);
        check("rst_rd",    rd_data, 0);
        Rst_n = 1'b1;

        // Good frame: 55 01 02 AA BB 68
        send(8'h55); send(8'h01); send(8'h02); send(8'hAA); send(8'hBB);
        check("good_valid_pre", frame_valid, 0);
        send(8'h68);
        check("good_valid", frame_valid, 1);
        check("good_err",   frame_err, 0);
        check("good_cmd",   cmd, 8'h01);
        check("good_len",   len, 8'h02);
        read_chk("good_rd0", 4'd0, 8'hAA);
        read_chk("good_rd1", 4'd1, 8'hBB);
        ack_chk("good_ack");

        // Garbage ignored, then oversized length 17
        send(8'h12);
        check("garbage_err", frame_err, 0);
        send(8'h34);
        send(8'h55); send(8'h01); send(8'h11);
        check("len_err",  frame_err, 1);
        check("len_code", err_code, 1);
        @(negedge Clk);
        check("len_pulse", frame_err, 0);

        // Bad checksum
        send(8'h55); send(8'h01); send(8'h02); send(8'hAA); send(8'hBB); send(8'h69);
        check("chk_err",   frame_err, 1);
        check("chk_code",  err_code, 0);
        check("chk_valid", frame_valid, 0);

        // Good frame after the bad one: sum 02+03+10+20+30 = 65
        send(8'h55); send(8'h02); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h65);
        check("g2_valid", frame_valid, 1);
        check("g2_cmd",   cmd, 8'h02);
        check("g2_len",   len, 8'h03);
        read_chk("g2_rd2", 4'd2, 8'h30);
        ack_chk("g2_ack");

        // Zero-length frame; buffer[0] still holds 10 from the previous frame
        send(8'h55); send(8'h10); send(8'h00); send(8'h10);
        check("zl_valid", frame_valid, 1);
        check("zl_len",   len, 8'h00);
        check("zl_cmd",   cmd, 8'h10);
        read_chk("zl_stale", 4'd0, 8'h10);
        ack_chk("zl_ack");

        // Header byte inside payload is data: 03+01+55 = 59
        send(8'h55); send(8'h03); send(8'h01); send(8'h55); send(8'h59);
        check("hd_valid", frame_valid, 1);
        read_chk("hd_rd0", 4'd0, 8'h55);
        ack_chk("hd_ack");

        // Overrun while held
        send(8'h55); send(8'h01); send(8'h02); send(8'hAA); send(8'hBB); send(8'h68);
        send(8'h77);
        check("ovr_err",   frame_err, 1);
        check("ovr_code",  err_code, 3);
        check("ovr_valid", frame_valid, 1);
        check("ovr_cmd",   cmd, 8'h01);
        read_chk("ovr_rd0", 4'd0, 8'hAA);
        read_chk("ovr_rd1", 4'd1, 8'hBB);

        // Ack and byte in the same cycle: byte (a header) dropped
        @(negedge Clk);
        frame_ack = 1'b1;
        data_byte = 8'h55;
        Rx_Done   = 1'b1;
        @(negedge Clk);
        frame_ack = 1'b0;
        Rx_Done   = 1'b0;
        check("sc_valid", frame_valid, 0);
        check("sc_err",   frame_err, 1);
        check("sc_code",  err_code, 3);
        send(8'h55); send(8'h05); send(8'h00); send(8'h05);
        check("sc_next_valid", frame_valid, 1);
        check("sc_next_cmd",   cmd, 8'h05);
        ack_chk("sc_next_ack");

`ifdef UART_CMD_TIMEOUT_EN
        send(8'h55); send(8'h01);
        repeat (99) @(negedge Clk);
        check("to_early", frame_err, 0);
        @(negedge Clk);
        check("to_err",  frame_err, 1);
        check("to_code", err_code, 2);
        // 99-cycle gap: the byte lands on the expiry cycle and wins
        send(8'h55); send(8'h01);
        repeat (98) @(negedge Clk);
        send(8'h00);
        check("gap_err", frame_err, 0);
        send(8'h01);
        check("gap_valid", frame_valid, 1);
        ack_chk("gap_ack");
`else
        send(8'h55); send(8'h01);
        repeat (1000) @(negedge Clk);
        check("nto_err",  frame_err, 0);
        check("nto_code", err_code, 3);
        send(8'h00); send(8'h01);
        check("nto_valid", frame_valid, 1);
        ack_chk("nto_ack");
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
